// File: rtl/voxel_gpu_sequencer.sv
// voxel_gpu_sequencer: command-queued front-end for the voxel GPU shader banks.
// HPS pushes commands over s1 into a FIFO; commands are issued to all banks in
// the bank mask, completion is tracked per bank, WRITE_OUT streams one pixel per
// masked bank over m1. Optional perf counters: define VOXEL_GPU_SEQ_PERF_EN.

// Per-bank completion tracker: remembers a done seen during the current WAIT.
module voxel_gpu_seq_lane (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic capture,
  input  logic en,
  input  logic done,
  output logic sat
);
  logic done_q;

  // Sticky done flag, cleared at issue, set by a done pulse while waiting
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                     done_q <= 1'b0;
    else if (clear)                done_q <= 1'b0;
    else if (capture && en && done) done_q <= 1'b1;
  end

  // Unmasked banks are always satisfied so an empty mask completes at once
  assign sat = !en || done_q || done;
endmodule

module voxel_gpu_sequencer #(
  parameter int NUM_BANKS      = 4,
  parameter int FIFO_DEPTH     = 8,
  parameter int PIXEL_BITS     = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [7:0]                       s1_address,
  input  logic                             s1_read,
  input  logic                             s1_write,
  input  logic [31:0]                      s1_writedata,
  output logic [31:0]                      s1_readdata,
  output logic                             s1_waitrequest,
  output logic                             irq,
  output logic [NUM_BANKS-1:0]             bank_start,
  output logic [2:0]                       bank_op,
  output logic [31:0]                      bank_arg,
  input  logic [NUM_BANKS-1:0]             bank_done,
  input  logic [NUM_BANKS*PIXEL_BITS-1:0]  bank_pixel,
  output logic [31:0]                      m1_address,
  output logic [PIXEL_BITS-1:0]            m1_writedata,
  output logic                             m1_write,
  input  logic                             m1_waitrequest
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int KW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam logic [2:0]  OP_WRITE_OUT = 3'd2;
  localparam logic [31:0] TO_LAST      = 32'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_WRITE, S_ERROR} state_t;
  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] arg;
  } cmd_t;

  state_t state, nxt;
  cmd_t   fifo_mem [FIFO_DEPTH];
  cmd_t   cmd_q;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [NUM_BANKS-1:0] mask, pend, pend_next, sat;
  logic [NUM_BANKS-1:0][PIXEL_BITS-1:0] pix;
  logic [KW-1:0] cur_k;
  logic          found;
  logic [31:0]   wait_cnt;
  logic [1:0]    err_code;
  logic          irq_pending, irq_en;
  logic wr_push, wr_mask, wr_ctrl, rd_stat, fifo_full, fifo_empty;
  logic clear_err, pop, push_ok, overflow, all_done, write_done, complete, timeout;
  logic [31:0] status;

  assign pix        = bank_pixel;
  assign wr_push    = s1_write && (s1_address <= 8'h04);
  assign wr_mask    = s1_write && (s1_address == 8'h0e);
  assign wr_ctrl    = s1_write && (s1_address == 8'h0f);
  assign rd_stat    = s1_read  && (s1_address == 8'h0f);
  assign fifo_full  = (count == CW'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  assign clear_err  = wr_ctrl && s1_writedata[0] && (state == S_ERROR);
  assign pop        = (state == S_IDLE) && !fifo_empty;
  // A pop in the same cycle frees a slot, so a push on a full FIFO still fits
  assign push_ok    = wr_push && (!fifo_full || pop);
  assign overflow   = wr_push && fifo_full && !pop;

  // Command FIFO pointers and level; clearing an error flushes everything queued
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear_err) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push_ok) - CW'(pop);
    end
  end

  // FIFO storage, opcode taken from the push register address
  always_ff @(posedge clock) begin
    if (push_ok) fifo_mem[wr_ptr] <= '{op: s1_address[2:0], arg: s1_writedata};
  end

  // Current command register, loaded on pop and held until the next pop
  always_ff @(posedge clock or posedge reset) begin
    if (reset)    cmd_q <= '0;
    else if (pop) cmd_q <= fifo_mem[rd_ptr];
  end

  genvar b;
  generate
    for (b = 0; b < NUM_BANKS; b++) begin : g_lane
      voxel_gpu_seq_lane u_lane (
        .clock   (clock),
        .reset   (reset),
        .clear   (state == S_ISSUE),
        .capture (state == S_WAIT),
        .en      (mask[b]),
        .done    (bank_done[b]),
        .sat     (sat[b])
      );
    end
  endgenerate

  assign all_done = &sat;

  // Lowest still-pending bank is the current write-out beat
  always_comb begin
    cur_k     = '0;
    found     = 1'b0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (pend[i] && !found) begin
        cur_k = KW'(i);
        found = 1'b1;
      end
    end
    pend_next        = pend;
    pend_next[cur_k] = 1'b0;
  end

  // Pending write-out banks: snapshot of mask at issue, retire one per accepted beat
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                                  pend <= '0;
    else if (state == S_ISSUE)                                  pend <= mask;
    else if (state == S_WRITE && found && !m1_waitrequest)      pend <= pend_next;
  end

  assign write_done = (state == S_WRITE) &&
                      (!found || (pend_next == '0 && !m1_waitrequest));
  assign complete   = ((state == S_WAIT) && all_done) || write_done;
  assign timeout    = ((state == S_WAIT) || (state == S_WRITE)) && !complete &&
                      (wait_cnt == TO_LAST);

  // Cycles spent waiting on the current command
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                         wait_cnt <= '0;
    else if (state == S_ISSUE)                         wait_cnt <= '0;
    else if (state == S_WAIT || state == S_WRITE)      wait_cnt <= wait_cnt + 32'd1;
  end

  // FSM state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= nxt;
  end

  // FSM next state; an overflow from any state forces ERROR
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  if (pop) nxt = S_ISSUE;
      S_ISSUE: nxt = (cmd_q.op == OP_WRITE_OUT) ? S_WRITE : S_WAIT;
      S_WAIT,
      S_WRITE: begin
        if (complete)     nxt = S_IDLE;
        else if (timeout) nxt = S_ERROR;
      end
      S_ERROR: if (clear_err) nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
    if (overflow) nxt = S_ERROR;
  end

  // FSM outputs; m1 bus is zero outside an active beat
  always_comb begin
    bank_start   = '0;
    m1_write     = 1'b0;
    m1_address   = '0;
    m1_writedata = '0;
    if (state == S_ISSUE) bank_start = mask;
    if (state == S_WRITE && found) begin
      m1_write     = 1'b1;
      m1_address   = cmd_q.arg + (32'(cur_k) << 1);
      m1_writedata = pix[cur_k];
    end
  end

  assign bank_op        = cmd_q.op;
  assign bank_arg       = cmd_q.arg;
  assign s1_waitrequest = 1'b0;
  assign irq            = irq_pending && irq_en;

  // Error code latch: overflow wins over a same-cycle timeout
  always_ff @(posedge clock or posedge reset) begin
    if (reset)          err_code <= 2'd0;
    else if (overflow)  err_code <= 2'd1;
    else if (timeout)   err_code <= 2'd2;
    else if (clear_err) err_code <= 2'd0;
  end

  // Batch-done interrupt; a new set beats a same-cycle status-read clear
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                       irq_pending <= 1'b0;
    else if (complete && fifo_empty) irq_pending <= 1'b1;
    else if (rd_stat)                irq_pending <= 1'b0;
  end

  // Control register and bank mask; mask only changes between commands
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      irq_en <= 1'b0;
      mask   <= '1;
    end else begin
      if (wr_ctrl)                      irq_en <= s1_writedata[1];
      if (wr_mask && state == S_IDLE)   mask   <= s1_writedata[NUM_BANKS-1:0];
    end
  end

`ifdef VOXEL_GPU_SEQ_PERF_EN
  logic [31:0] busy_cnt, cmd_cnt;

  // Perf counters: busy cycles and completed commands, cleared by a 0x0c write
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy_cnt <= '0;
      cmd_cnt  <= '0;
    end else if (s1_write && s1_address == 8'h0c) begin
      busy_cnt <= '0;
      cmd_cnt  <= '0;
    end else begin
      if (state != S_IDLE && state != S_ERROR) busy_cnt <= busy_cnt + 32'd1;
      if (complete)                            cmd_cnt  <= cmd_cnt + 32'd1;
    end
  end
`endif

  // Slave read mux, purely combinational from the address
  always_comb begin
    status        = '0;
    status[0]     = (state != S_IDLE) || !fifo_empty;
    status[1]     = (state == S_ERROR);
    status[2]     = irq_pending;
    status[5:4]   = err_code;
    status[15:8]  = 8'(count);
    s1_readdata   = '0;
    case (s1_address)
      8'h0e: s1_readdata = 32'(mask);
      8'h0f: s1_readdata = status;
`ifdef VOXEL_GPU_SEQ_PERF_EN
      8'h0c: s1_readdata = busy_cnt;
      8'h0d: s1_readdata = cmd_cnt;
`endif
      default: s1_readdata = '0;
    endcase
  end
endmodule

// File: tb/tb_voxel_gpu_sequencer.sv
// Self-checking bench for voxel_gpu_sequencer: register tables plus directed
// sequences; bank_start pulses and m1 beats are checked against queues.
module tb_voxel_gpu_sequencer;
  localparam int NB = 4;
  localparam int PB = 16;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [7:0]      s1_address = '0;
  logic            s1_read = 1'b0;
  logic            s1_write = 1'b0;
  logic [31:0]     s1_writedata = '0;
  logic [31:0]     s1_readdata;
  logic            s1_waitrequest, irq;
  logic [NB-1:0]   bank_start, bank_done;
  logic [2:0]      bank_op;
  logic [31:0]     bank_arg;
  logic [NB*PB-1:0] bank_pixel = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
  logic [31:0]     m1_address;
  logic [PB-1:0]   m1_writedata;
  logic            m1_write;
  logic            m1_waitrequest = 1'b0;

  logic          auto_en = 1'b0;
  logic [NB-1:0] done_man = '0;
  logic [NB-1:0] start_d;
  logic          rec_en = 1'b0;
  int            checks = 0;
  int            failures = 0;
  int            cyc = 0;
  int            start_cyc[$];

  typedef struct { logic [3:0] start; logic [31:0] arg; } st_exp_t;
  typedef struct { logic [31:0] addr; logic [15:0] data; } bt_exp_t;
  typedef struct { logic [7:0] addr; logic [31:0] exp; string name; } rd_vec_t;
  st_exp_t exp_st[$];
  bt_exp_t exp_bt[$];
  st_exp_t e_st;
  bt_exp_t e_bt;

  voxel_gpu_sequencer #(
    .NUM_BANKS(NB), .FIFO_DEPTH(8), .PIXEL_BITS(PB), .TIMEOUT_CYCLES(16)
  ) dut (
    .clock(clock), .reset(reset),
    .s1_address(s1_address), .s1_read(s1_read), .s1_write(s1_write),
    .s1_writedata(s1_writedata), .s1_readdata(s1_readdata),
    .s1_waitrequest(s1_waitrequest), .irq(irq),
    .bank_start(bank_start), .bank_op(bank_op), .bank_arg(bank_arg),
    .bank_done(bank_done), .bank_pixel(bank_pixel),
    .m1_address(m1_address), .m1_writedata(m1_writedata), .m1_write(m1_write),
    .m1_waitrequest(m1_waitrequest)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Auto responder: every started bank reports done one cycle after its start
  always @(posedge clock or posedge reset)
    if (reset) start_d <= '0;
    else       start_d <= bank_start;
  assign bank_done = auto_en ? start_d : done_man;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
    end
  endtask

  // Scoreboard monitor, sampled on the falling edge
  always @(negedge clock) begin
    if (!reset) begin
      if (bank_start != '0) begin
        if (rec_en) start_cyc.push_back(cyc);
        if (exp_st.size() == 0) chk("unexp_start", 32'(bank_start), 32'h0);
        else begin
          e_st = exp_st.pop_front();
          chk("start_mask", 32'(bank_start), 32'(e_st.start));
          chk("start_arg", bank_arg, e_st.arg);
        end
      end
      if (m1_write && !m1_waitrequest) begin
        if (exp_bt.size() == 0) chk("unexp_beat", m1_address, 32'hffff_ffff);
        else begin
          e_bt = exp_bt.pop_front();
          chk("beat_addr", m1_address, e_bt.addr);
          chk("beat_data", 32'(m1_writedata), 32'(e_bt.data));
        end
      end
    end
  end

  task automatic step;
    @(posedge clock); #1;
  endtask

  task automatic s1_wr(input logic [7:0] a, input logic [31:0] d);
    s1_address = a; s1_writedata = d; s1_write = 1'b1;
    step();
    s1_write = 1'b0;
  endtask

  task automatic rd_chk(input string n, input logic [7:0] a, input logic [31:0] e);
    logic [31:0] d;
    s1_address = a; s1_read = 1'b1;
    #2 d = s1_readdata;
    step();
    s1_read = 1'b0;
    chk(n, d, e);
  endtask

  task automatic wait_m1(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (m1_write) begin seen = 1'b1; break; end
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rd_vec_t reset_tab[6];
    rd_vec_t final_tab[4];
    bit bad, seen;
    logic [31:0] st;

    reset_tab[0] = '{8'h0e, 32'h0000_000f, "rst_mask"};
    reset_tab[1] = '{8'h0f, 32'h0000_0000, "rst_status"};
    reset_tab[2] = '{8'h0c, 32'h0000_0000, "rst_perf0"};
    reset_tab[3] = '{8'h0d, 32'h0000_0000, "rst_perf1"};
    reset_tab[4] = '{8'h00, 32'h0000_0000, "rst_push_rd"};
    reset_tab[5] = '{8'h55, 32'h0000_0000, "rst_unmapped"};
    final_tab[0] = '{8'h0c, 32'h0000_0000, "end_perf0"};
    final_tab[1] = '{8'h0d, 32'h0000_0000, "end_perf1"};
    final_tab[2] = '{8'h0e, 32'h0000_000f, "end_mask"};
    final_tab[3] = '{8'h0f, 32'h0000_0000, "end_status"};

    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    step();

    // Reset state
    chk("rst_bank_start", 32'(bank_start), 32'h0);
    chk("rst_m1_write", 32'(m1_write), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_bank_arg", bank_arg, 32'h0);
    chk("rst_waitreq", 32'(s1_waitrequest), 32'h0);
    for (int i = 0; i < 6; i++) rd_chk(reset_tab[i].name, reset_tab[i].addr, reset_tab[i].exp);

    // Single RASTERIZE with staggered dones, irq on batch completion
    s1_wr(8'h0f, 32'h2);
    exp_st.push_back('{4'hf, 32'h1234_5678});
    s1_wr(8'h00, 32'h1234_5678);
    chk("pop_cycle_no_start", 32'(bank_start), 32'h0);
    step();
    chk("start_at_t2", 32'(bank_start), 32'hf);
    chk("op_rasterize", 32'(bank_op), 32'h0);
    for (int c = 1; c <= 9; c++) begin
      step();
      done_man = ((c == 3) ? 4'b0001 : 4'b0000) | ((c == 5) ? 4'b0110 : 4'b0000) |
                 ((c == 9) ? 4'b1000 : 4'b0000);
      if (c == 5) chk("arg_held", bank_arg, 32'h1234_5678);
      if (c == 9) chk("irq_before_last_done", 32'(irq), 32'h0);
    end
    step();
    done_man = '0;
    chk("irq_after_done", 32'(irq), 32'h1);
    rd_chk("status_irq", 8'h0f, 32'h4);
    rd_chk("status_cleared", 8'h0f, 32'h0);
    chk("irq_cleared", 32'(irq), 32'h0);

    // Three SHADE commands back-to-back, done one cycle after each start
    start_cyc.delete();
    rec_en = 1'b1;
    auto_en = 1'b1;
    for (int i = 0; i < 3; i++) exp_st.push_back('{4'hf, 32'ha000_0000 + 32'(i)});
    for (int i = 0; i < 3; i++) s1_wr(8'h01, 32'ha000_0000 + 32'(i));
    bad = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (irq) bad = 1'b1;
      step();
    end
    chk("irq_not_early", 32'(bad), 32'h0);
    chk("irq_after_third", 32'(irq), 32'h1);
    auto_en = 1'b0;
    rec_en = 1'b0;
    chk("start_count", 32'(start_cyc.size()), 32'd3);
    if (start_cyc.size() == 3) begin
      chk("start_gap1", 32'(start_cyc[1] - start_cyc[0]), 32'd3);
      chk("start_gap2", 32'(start_cyc[2] - start_cyc[1]), 32'd3);
    end
    rd_chk("status_shade", 8'h0f, 32'h4);

    // WRITE_OUT with mask 0101 and two waitrequest cycles per beat
    s1_wr(8'h0e, 32'h5);
    m1_waitrequest = 1'b1;
    exp_st.push_back('{4'h5, 32'h0800_0000});
    exp_bt.push_back('{32'h0800_0000, 16'h1111});
    exp_bt.push_back('{32'h0800_0004, 16'h3333});
    s1_wr(8'h02, 32'h0800_0000);
    wait_m1(seen);
    chk("m1_seen", 32'(seen), 32'h1);
    step();
    chk("m1_addr_stable", m1_address, 32'h0800_0000);
    chk("m1_data_stable", 32'(m1_writedata), 32'h1111);
    m1_waitrequest = 1'b0;
    step();
    m1_waitrequest = 1'b1;
    chk("m1_addr_beat2", m1_address, 32'h0800_0004);
    step();
    chk("m1_write_held", 32'(m1_write), 32'h1);
    m1_waitrequest = 1'b0;
    step();
    m1_waitrequest = 1'b1;
    chk("m1_write_done", 32'(m1_write), 32'h0);
    m1_waitrequest = 1'b0;
    rd_chk("status_wr", 8'h0f, 32'h4);

    // Timeout: bank 1 never done, ERROR 16 cycles after WAIT entry
    s1_wr(8'h0e, 32'hf);
    done_man = 4'b1101;
    exp_st.push_back('{4'hf, 32'hcafe_0001});
    s1_wr(8'h01, 32'hcafe_0001);
    s1_address = 8'h0f;
    bad = 1'b0;
    for (int i = 1; i <= 18; i++) begin
      if (s1_readdata[1]) bad = 1'b1;
      step();
    end
    st = s1_readdata;
    chk("err_not_early", 32'(bad), 32'h0);
    chk("err_at_timeout", 32'(st[1]), 32'h1);
    chk("err_code_timeout", 32'(st[5:4]), 32'h2);
    repeat (5) step();
    s1_wr(8'h0e, 32'h3);
    s1_wr(8'h00, 32'h77);
    rd_chk("status_err_push", 8'h0f, 32'h123);
    rd_chk("mask_ignored", 8'h0e, 32'hf);
    s1_wr(8'h0f, 32'h1);
    rd_chk("status_clr_to", 8'h0f, 32'h0);
    done_man = '0;

    // Overflow: one entry popped into the command register, then 8 fill the
    // FIFO, so the tenth consecutive push is the one that overflows
    exp_st.push_back('{4'hf, 32'h0});
    for (int i = 0; i < 10; i++) s1_wr(8'h00, 32'(i));
    rd_chk("status_overflow", 8'h0f, 32'h813);
    s1_wr(8'h0f, 32'h1);
    rd_chk("status_clr_ovf", 8'h0f, 32'h0);

    // Reset in the middle of a stalled write-out
    s1_wr(8'h0e, 32'h5);
    m1_waitrequest = 1'b1;
    exp_st.push_back('{4'h5, 32'h0800_0100});
    s1_wr(8'h02, 32'h0800_0100);
    s1_wr(8'h00, 32'h55);
    wait_m1(seen);
    chk("m1_seen_rst", 32'(seen), 32'h1);
    #2 reset = 1'b1;
    #1;
    chk("rst_drops_m1", 32'(m1_write), 32'h0);
    chk("rst_drops_start", 32'(bank_start), 32'h0);
    step();
    reset = 1'b0;
    m1_waitrequest = 1'b0;
    step();
    for (int i = 0; i < 4; i++) rd_chk(final_tab[i].name, final_tab[i].addr, final_tab[i].exp);

    chk("st_queue_empty", 32'(exp_st.size()), 32'h0);
    chk("beat_queue_empty", 32'(exp_bt.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
